apb_uart_bridge: RTL and testbench



---
 rtl/apb_uart_bridge_pkg.sv | 41 ++++
 rtl/apb_uart_bridge_if.sv | 24 ++
 rtl/apb_uart_bridge_sync_fifo.sv | 74 +++++++
 rtl/apb_uart_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_apb_uart_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_uart_bridge_pkg.sv
// Shared definitions for the APB UART bridge:
// register map, STATUS/CTRL bit positions and TX state encoding.
package uart_bridge_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_OVERRUN  = 4;
  localparam int ST_FRAME    = 5;
  localparam int ST_TX_BUSY  = 6;

  localparam int CT_TX_EN    = 0;
  localparam int CT_RX_EN    = 1;
  localparam int CT_TX_FLUSH = 2;
  localparam int CT_RX_FLUSH = 3;
  localparam int CT_RX_IE    = 4;
  localparam int CT_TX_IE    = 5;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_WAIT
  } tx_state_e;

  typedef struct packed {
    logic tx_ie;
    logic rx_ie;
    logic rx_en;
    logic tx_en;
  } ctrl_t;

  function automatic logic [7:0] cnt8(input logic [31:0] c);
    return c[7:0];
  endfunction

endpackage

// File: rtl/apb_uart_bridge_if.sv
// APB bus bundle between the processor side and the UART bridge.
// master drives the request, slave returns data and completion.
interface apb_uart_bridge_if;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_uart_bridge_sync_fifo.sv
// Synchronous FIFO; full/empty come from the registered count,
// so a same-cycle pop never makes room for a push.
import uart_bridge_pkg::*;

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage needs no reset; the count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/apb_uart_bridge.sv
// APB slave bridging the CPU bus to the UART TX/RX cores
// through independent TX and RX FIFOs with sticky error flags.
import uart_bridge_pkg::*;

module apb_uart_bridge #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  apb_uart_bridge_if.slave  apb,
  output logic              txStart,
  output logic [DATA_W-1:0] txData,
  input  logic              txDone,
  input  logic [DATA_W-1:0] rxData,
  input  logic              rxDone,
  input  logic              err_in,
  output logic              irq
);

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic              pready_q, pready_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;
  logic              irq_q, irq_d;
  tx_state_e         state_q;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;

  logic              tx_push, tx_pop, tx_flush;
  logic              tx_full, tx_empty;
  logic [DATA_W-1:0] tx_dout;
  logic [TCW-1:0]    tx_count;
  logic              rx_push, rx_pop, rx_flush;
  logic              rx_full, rx_empty;
  logic [DATA_W-1:0] rx_dout;
  logic [RCW-1:0]    rx_count;

  logic              is_data, is_stat, is_ctrl;
  logic              fire, stat_w, ctrl_w;
  logic              tx_busy;
  logic [31:0]       status, rdata;
  logic              slverr;
  logic              unused_pwdata;

  assign unused_pwdata = ^apb.pwdata;

  assign is_data = apb.paddr == ADDR_DATA;
  assign is_stat = apb.paddr == ADDR_STATUS;
  assign is_ctrl = apb.paddr == ADDR_CTRL;
  assign tx_busy = state_q != T_IDLE;

  always_comb begin
    status                 = '0;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_RX_EMPTY]    = rx_empty;
    status[ST_RX_FULL]     = rx_full;
    status[ST_OVERRUN]     = ovr_q;
    status[ST_FRAME]       = ferr_q;
    status[ST_TX_BUSY]     = tx_busy;
    status[15:8]           = cnt8(32'(tx_count));
    status[23:16]          = cnt8(32'(rx_count));
  end

  always_comb begin
    rdata  = '0;
    slverr = 1'b0;
    unique case (1'b1)
      is_data: begin
        if (apb.pwrite)    slverr = tx_full;
        else if (rx_empty) slverr = 1'b1;
        else               rdata  = 32'(rx_dout);
      end
      is_stat: begin
        if (!apb.pwrite) rdata = status;
      end
      is_ctrl: begin
        if (!apb.pwrite) begin
          rdata[CT_TX_EN] = ctrl_q.tx_en;
          rdata[CT_RX_EN] = ctrl_q.rx_en;
          rdata[CT_RX_IE] = ctrl_q.rx_ie;
          rdata[CT_TX_IE] = ctrl_q.tx_ie;
        end
      end
      default: slverr = 1'b1;
    endcase
  end

  assign apb.pready  = pready_q;
  assign apb.prdata  = pready_q ? rdata : '0;
  assign apb.pslverr = pready_q & slverr;

  // the single side effect of a transfer lands on its pready cycle
  assign fire     = pready_q & ~slverr;
  assign tx_push  = fire & is_data & apb.pwrite;
  assign rx_pop   = fire & is_data & ~apb.pwrite;
  assign stat_w   = fire & is_stat & apb.pwrite;
  assign ctrl_w   = fire & is_ctrl & apb.pwrite;
  assign tx_flush = ctrl_w & apb.pwdata[CT_TX_FLUSH];
  assign rx_flush = ctrl_w & apb.pwdata[CT_RX_FLUSH];
  assign tx_pop   = ~tx_busy & ctrl_q.tx_en & ~tx_empty & ~tx_flush;
  assign rx_push  = rxDone & ctrl_q.rx_en;

  always_comb begin
    pready_d = apb.psel & apb.penable & ~pready_q;
    ctrl_d   = ctrl_q;
    if (ctrl_w) begin
      ctrl_d.tx_en = apb.pwdata[CT_TX_EN];
      ctrl_d.rx_en = apb.pwdata[CT_RX_EN];
      ctrl_d.rx_ie = apb.pwdata[CT_RX_IE];
      ctrl_d.tx_ie = apb.pwdata[CT_TX_IE];
    end
    ovr_d  = (ovr_q & ~(stat_w & apb.pwdata[ST_OVERRUN]))
           | (rx_push & rx_full);
    ferr_d = (ferr_q & ~(stat_w & apb.pwdata[ST_FRAME]))
           | err_in;
    irq_d  = (ctrl_q.rx_ie & ~rx_empty)
           | (ctrl_q.tx_ie & tx_empty & ~tx_busy)
           | ovr_q | ferr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready_q <= 1'b0;
      ctrl_q   <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      pready_q <= pready_d;
      ctrl_q   <= ctrl_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= T_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        T_IDLE: begin
          if (tx_pop) begin
            tx_data_q  <= tx_dout;
            tx_start_q <= 1'b1;
            state_q    <= T_START;
          end
        end
        T_START: state_q <= T_WAIT;
        T_WAIT:  if (txDone) state_q <= T_IDLE;
        default: state_q <= T_IDLE;
      endcase
    end
  end

  assign txStart = tx_start_q;
  assign txData  = tx_data_q;
  assign irq     = irq_q;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (apb.pwdata[DATA_W-1:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rxData),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

endmodule

// File: tb/tb_apb_uart_bridge.sv
// Bench for apb_uart_bridge: queue-based reference model compared
// every cycle, directed scenarios with literal values, then random traffic.
module tb_apb_uart_bridge;

  localparam int TXD = 4;
  localparam int RXD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       txStart;
  logic [7:0] txData;
  logic       txDone = 1'b0;
  logic [7:0] rxData = '0;
  logic       rxDone = 1'b0;
  logic       err_in = 1'b0;
  logic       irq;

  apb_uart_bridge_if bus ();

  apb_uart_bridge #(
    .DATA_W   (8),
    .TX_DEPTH (TXD),
    .RX_DEPTH (RXD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .apb     (bus),
    .txStart (txStart),
    .txData  (txData),
    .txDone  (txDone),
    .rxData  (rxData),
    .rxDone  (rxDone),
    .err_in  (err_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rand_on = 1'b0;
  logic [7:0] tx_log[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mtx[$];
  logic [7:0] mrx[$];
  bit m_pready = 0, m_txen = 0, m_rxen = 0, m_rxie = 0, m_txie = 0;
  bit m_ov = 0, m_fe = 0, m_irq = 0;
  int m_phase = 0;
  logic [7:0] m_txdata = '0;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = mtx.size() == 0;
    s[1] = mtx.size() == TXD;
    s[2] = mrx.size() == 0;
    s[3] = mrx.size() == RXD;
    s[4] = m_ov;
    s[5] = m_fe;
    s[6] = m_phase != 0;
    s[15:8] = 8'(mtx.size());
    s[23:16] = 8'(mrx.size());
    return s;
  endfunction

  function automatic void m_resp(output logic [31:0] rd, output logic er);
    rd = '0;
    er = 1'b0;
    case (bus.paddr)
      4'h0: begin
        if (bus.pwrite) er = mtx.size() == TXD;
        else if (mrx.size() == 0) er = 1'b1;
        else rd = {24'b0, mrx[0]};
      end
      4'h4: if (!bus.pwrite) rd = m_status();
      4'h8: if (!bus.pwrite)
              rd = {26'b0, m_txie, m_rxie, 2'b00, m_rxen, m_txen};
      default: er = 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    logic [31:0] rd;
    logic er;
    bit txfl, rxfl, push, pop, rxpop, rxpush, ovset, w4, w5, cw;
    int ntx, nrx;
    bit nirq;
    if (!rst_n) begin
      mtx.delete(); mrx.delete();
      m_pready = 0; m_txen = 0; m_rxen = 0; m_rxie = 0; m_txie = 0;
      m_ov = 0; m_fe = 0; m_irq = 0; m_phase = 0; m_txdata = '0;
    end else begin
      ntx = mtx.size();
      nrx = mrx.size();
      nirq = (m_rxie && nrx != 0) || (m_txie && ntx == 0 && m_phase == 0)
             || m_ov || m_fe;
      txfl = 0; rxfl = 0; push = 0; rxpop = 0; w4 = 0; w5 = 0; cw = 0;
      if (m_pready) begin
        m_resp(rd, er);
        if (!er) begin
          if (bus.paddr == 4'h0 && bus.pwrite) push = 1;
          if (bus.paddr == 4'h0 && !bus.pwrite) rxpop = 1;
          if (bus.paddr == 4'h4 && bus.pwrite) begin
            w4 = bus.pwdata[4]; w5 = bus.pwdata[5];
          end
          if (bus.paddr == 4'h8 && bus.pwrite) begin
            cw = 1; txfl = bus.pwdata[2]; rxfl = bus.pwdata[3];
          end
        end
      end
      pop    = m_phase == 0 && m_txen && ntx != 0 && !txfl;
      rxpush = rxDone && m_rxen && nrx < RXD;
      ovset  = rxDone && m_rxen && nrx == RXD;
      if (m_phase == 0 && pop) begin
        m_txdata = mtx[0];
        m_phase = 1;
      end else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && txDone) m_phase = 0;
      if (txfl) mtx.delete();
      else begin
        if (pop) void'(mtx.pop_front());
        if (push) mtx.push_back(bus.pwdata[7:0]);
      end
      if (rxfl) mrx.delete();
      else begin
        if (rxpop) void'(mrx.pop_front());
        if (rxpush) mrx.push_back(rxData);
      end
      m_ov = (m_ov && !w4) || ovset;
      m_fe = (m_fe && !w5) || err_in;
      if (cw) begin
        m_txen = bus.pwdata[0]; m_rxen = bus.pwdata[1];
        m_rxie = bus.pwdata[4]; m_txie = bus.pwdata[5];
      end
      m_pready = bus.psel && bus.penable && !m_pready;
      m_irq = nirq;
    end
  end

  always @(negedge clk) begin : cmp
    logic [31:0] erd;
    logic ee;
    if (m_pready) m_resp(erd, ee);
    else begin erd = '0; ee = 1'b0; end
    chk("pready", 32'(bus.pready), 32'(m_pready));
    chk("prdata", bus.prdata, erd);
    chk("pslverr", 32'(bus.pslverr), 32'(ee));
    chk("txStart", 32'(txStart), 32'(m_phase == 1));
    chk("txData", 32'(txData), 32'(m_txdata));
    chk("irq", 32'(irq), 32'(m_irq));
    if (txStart) tx_log.push_back(txData);
  end

  // TX core stand-in: answers each txStart with a txDone pulse
  initial begin : responder
    int d;
    forever begin
      @(negedge clk);
      if (txStart) begin
        d = rand_on ? $urandom_range(1, 6) : 10;
        repeat (d) @(posedge clk);
        #1 txDone = 1'b1;
        @(posedge clk);
        #1 txDone = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic apb(input bit wr, input logic [3:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic er, input bit dir, input bit coinc = 0);
    int n;
    @(posedge clk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = wr;
    bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pready && n < 8);
    if (dir) chk("apb_wait", 32'(n), 32'd2);
    else if (n >= 8) chk("apb_timeout", 32'(n), 32'd2);
    rd = bus.prdata;
    er = bus.pslverr;
    if (coinc) begin
      rxDone = 1; rxData = 8'hC5;
    end
    @(posedge clk); #1;
    bus.psel = 0; bus.penable = 0;
    rxDone = 0;
  endtask

  task automatic rx_pulse(input logic [7:0] v);
    @(posedge clk); #1 rxDone = 1; rxData = v;
    @(posedge clk); #1 rxDone = 0;
  endtask

  task automatic wait_tx_idle();
    logic [31:0] rd;
    logic er;
    int k;
    k = 0;
    do begin
      apb(0, 4'h4, 0, rd, er, 1);
      k++;
    end while (!(rd[6] == 0 && rd[0] == 1) && k < 40);
    chk("tx_idle_reached", 32'(rd[6] == 0 && rd[0] == 1), 32'd1);
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    logic er;
    int n;
    logic [3:0] a;
    logic [31:0] wd;
    bit wr;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    bus.paddr = '0; bus.pwdata = '0;
    #3 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // 1: reset state
    @(negedge clk);
    chk("t1_txStart", 32'(txStart), 0);
    chk("t1_irq", 32'(irq), 0);
    chk("t1_prdata_idle", bus.prdata, 0);
    apb(0, 4'h4, 0, rd, er, 1);
    chk("t1_status", rd, 32'h5);
    chk("t1_err", 32'(er), 0);
    apb(0, 4'hC, 0, rd, er, 1);
    chk("t1_unmapped_err", 32'(er), 1);

    // 2: three characters in order
    tx_log.delete();
    apb(1, 4'h8, 32'h1, rd, er, 1);
    apb(1, 4'h0, 32'h11, rd, er, 1);
    apb(1, 4'h0, 32'h22, rd, er, 1);
    apb(1, 4'h0, 32'h33, rd, er, 1);
    wait_tx_idle();
    chk("t2_count", 32'(tx_log.size()), 3);
    if (tx_log.size() == 3) begin
      chk("t2_byte0", 32'(tx_log[0]), 32'h11);
      chk("t2_byte1", 32'(tx_log[1]), 32'h22);
      chk("t2_byte2", 32'(tx_log[2]), 32'h33);
    end
    apb(0, 4'h4, 0, rd, er, 1);
    chk("t2_status", rd, 32'h5);

    // 3: TX full and flush
    apb(1, 4'h8, 32'h0, rd, er, 1);
    for (int i = 0; i < 5; i++) begin
      apb(1, 4'h0, 32'h40 + 32'(i), rd, er, 1);
      chk("t3_wr_err", 32'(er), (i == 4) ? 32'd1 : 32'd0);
    end
    apb(0, 4'h4, 0, rd, er, 1);
    chk("t3_status_full", rd, 32'h406);
    apb(1, 4'h8, 32'h4, rd, er, 1);
    apb(0, 4'h4, 0, rd, er, 1);
    chk("t3_status_flushed", rd, 32'h5);

    // 4: RX overrun and empty read
    apb(1, 4'h8, 32'h2, rd, er, 1);
    for (int i = 0; i < 5; i++) rx_pulse(8'hA1 + 8'(i));
    apb(0, 4'h4, 0, rd, er, 1);
    chk("t4_status", rd, 32'h00040019);
    for (int i = 0; i < 5; i++) begin
      apb(0, 4'h0, 0, rd, er, 1);
      chk("t4_rd_data", rd, (i < 4) ? 32'hA1 + 32'(i) : 32'h0);
      chk("t4_rd_err", 32'(er), (i == 4) ? 32'd1 : 32'd0);
    end
    apb(1, 4'h4, 32'h10, rd, er, 1);
    apb(0, 4'h4, 0, rd, er, 1);
    chk("t4_status_w1c", rd, 32'h5);

    // 5: coincident pop and push on full RX, then frame error irq
    for (int i = 0; i < 4; i++) rx_pulse(8'hC1 + 8'(i));
    apb(0, 4'h0, 0, rd, er, 1, 1);
    chk("t5_rd_data", rd, 32'hC1);
    apb(0, 4'h4, 0, rd, er, 1);
    chk("t5_status", rd, 32'h00030011);
    apb(1, 4'h4, 32'h10, rd, er, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_irq_low", 32'(irq), 0);
    @(posedge clk); #1 err_in = 1;
    @(posedge clk); #1 err_in = 0;
    @(negedge clk);
    chk("t5_irq_latency", 32'(irq), 0);
    @(negedge clk);
    chk("t5_irq_high", 32'(irq), 1);

    // 6: async reset in the middle of a character
    apb(1, 4'h8, 32'h1, rd, er, 1);
    apb(1, 4'h0, 32'h5A, rd, er, 1);
    n = 0;
    while (!txStart && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_start_seen", 32'(txStart), 1);
    repeat (3) @(negedge clk);
    chk("t6_irq_before", 32'(irq), 1);
    #2 rst_n = 0;
    #1;
    chk("t6_txStart_rst", 32'(txStart), 0);
    chk("t6_irq_rst", 32'(irq), 0);
    chk("t6_pready_rst", 32'(bus.pready), 0);
    chk("t6_prdata_rst", bus.prdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    apb(0, 4'h4, 0, rd, er, 1);
    chk("t6_status", rd, 32'h5);

    // random traffic against the model
    rand_on = 1;
    fork
      begin
        repeat (300) begin
          n = $urandom_range(0, 9);
          if (n < 4) a = 4'h0;
          else if (n < 6) a = 4'h4;
          else if (n < 8) a = 4'h8;
          else a = 4'($urandom);
          wr = 1'($urandom);
          wd = $urandom;
          if (a == 4'h8) begin
            wd = ($urandom & 32'h30)
               | (($urandom % 4 != 0) ? 32'h3 : 32'h0)
               | (($urandom % 10 == 0) ? 32'h4 : 32'h0)
               | (($urandom % 10 == 0) ? 32'h8 : 32'h0);
          end
          apb(wr, a, wd, rd, er, 0);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rand_on = 0;
      end
      begin
        while (!rand_on) @(posedge clk);
        while (rand_on) begin
          @(posedge clk); #1;
          rxDone = ($urandom % 3 == 0);
          rxData = 8'($urandom);
          err_in = ($urandom % 20 == 0);
        end
        rxDone = 0;
        err_in = 0;
      end
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
